// File: rtl/prefix_pkg.sv
`timescale 1ns/1ps
// prefix_pkg: shared constants, the generate/propagate pair type and the
// Kogge-Stone combine operator for the pipelined prefix add/subtract unit.
//   WIDTH      : operand width (32 only)
//   LEVELS     : number of prefix levels (log2 WIDTH)
//   NGP        : length of the g/p vector (bits 0..31 plus the carry-in slot)
//   LEVEL_DIST : combine distance of each prefix level
package prefix_pkg;

  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;
  // Index 0 is the carry-in position (bit -1); index i+1 holds bit i.
  localparam int NGP    = WIDTH + 1;

  localparam int LEVEL_DIST [LEVELS] = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd16};

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Associative prefix operator: hi group absorbs the lower group.
  function automatic gp_t combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/prefix_addsub_pipe_level.sv
`timescale 1ns/1ps
// prefix_level: one registered Kogge-Stone level. Entries at index >= DIST
// are combined with the entry DIST below; lower entries pass through. The
// sum-propagate vector and the valid bit ride along untouched.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   en                 : pipeline advance enable (hold when low)
//   valid_i / valid_o  : beat valid into / out of this level
//   g_i, p_i / g_o, p_o: group generate/propagate vectors (NGP entries)
//   sp_i / sp_o        : per-bit sum propagate, carried for the final XOR
module prefix_level
  import prefix_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             valid_i,
  input  logic [NGP-1:0]   g_i,
  input  logic [NGP-1:0]   p_i,
  input  logic [WIDTH-1:0] sp_i,
  output logic             valid_o,
  output logic [NGP-1:0]   g_o,
  output logic [NGP-1:0]   p_o,
  output logic [WIDTH-1:0] sp_o
);

  logic [NGP-1:0] g_d;
  logic [NGP-1:0] p_d;
  gp_t            gp_tmp;

  // Prefix combine for this level's distance.
  always_comb begin
    g_d    = g_i;
    p_d    = p_i;
    gp_tmp = '{g: 1'b0, p: 1'b0};
    for (int k = DIST; k < NGP; k++) begin
      gp_tmp = combine(gp_t'{g: g_i[k], p: p_i[k]},
                       gp_t'{g: g_i[k-DIST], p: p_i[k-DIST]});
      g_d[k] = gp_tmp.g;
      p_d[k] = gp_tmp.p;
    end
  end

  // Level register: clears on reset, loads when the pipe advances, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      g_o     <= {NGP{1'b0}};
      p_o     <= {NGP{1'b0}};
      sp_o    <= {WIDTH{1'b0}};
    end else if (en) begin
      valid_o <= valid_i;
      g_o     <= g_d;
      p_o     <= p_d;
      sp_o    <= sp_i;
    end else begin
      valid_o <= valid_o;
      g_o     <= g_o;
      p_o     <= p_o;
      sp_o    <= sp_o;
    end
  end

endmodule

// File: rtl/prefix_addsub_pipe.sv
`timescale 1ns/1ps
// prefix_addsub_pipe: 32-bit add/subtract unit with a Kogge-Stone carry
// network, one register per prefix level (S0 operand stage + S1..S5), and a
// valid/ready handshake sustaining one beat per cycle.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake
//   op_a, op_b, sub      : operands; sub=1 selects A-B
//   out_valid / out_ready: result handshake
//   result               : sum or difference
//   cout, borrow, ovf    : carry out, borrow (sub & ~cout), signed overflow
//   zero                 : result == 0, only while out_valid
module prefix_addsub_pipe
  import prefix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  logic             en;
  logic [WIDTH-1:0] bb;
  logic [NGP-1:0]   s0_g_d;
  logic [NGP-1:0]   s0_p_d;
  logic [WIDTH-1:0] s0_sp_d;
  logic             s0_valid_q;
  logic [NGP-1:0]   s0_g_q;
  logic [NGP-1:0]   s0_p_q;
  logic [WIDTH-1:0] s0_sp_q;

  // Stage taps: index 0 is S0, index l is the output of prefix level l.
  logic             lv_valid [LEVELS+1];
  logic [NGP-1:0]   lv_g     [LEVELS+1];
  logic [NGP-1:0]   lv_p     [LEVELS+1];
  logic [WIDTH-1:0] lv_sp    [LEVELS+1];

  logic [NGP-1:0]   carry_full;
  gp_t              gp_tmp;

  // Whole pipe advances together unless the output beat is stalled.
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = lv_valid[LEVELS];

  // Operand stage: carry-in folded in as a pure generate at position -1.
  always_comb begin
    bb      = op_b ^ {WIDTH{sub}};
    s0_g_d  = {op_a & bb, sub};
    s0_p_d  = {op_a ^ bb, 1'b0};
    s0_sp_d = op_a ^ bb;
  end

  // S0 register: a bubble is loaded when in_valid is low and en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_g_q     <= {NGP{1'b0}};
      s0_p_q     <= {NGP{1'b0}};
      s0_sp_q    <= {WIDTH{1'b0}};
    end else if (en) begin
      s0_valid_q <= in_valid;
      s0_g_q     <= s0_g_d;
      s0_p_q     <= s0_p_d;
      s0_sp_q    <= s0_sp_d;
    end else begin
      s0_valid_q <= s0_valid_q;
      s0_g_q     <= s0_g_q;
      s0_p_q     <= s0_p_q;
      s0_sp_q    <= s0_sp_q;
    end
  end

  assign lv_valid[0] = s0_valid_q;
  assign lv_g[0]     = s0_g_q;
  assign lv_p[0]     = s0_p_q;
  assign lv_sp[0]    = s0_sp_q;

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    prefix_level #(
      .DIST(LEVEL_DIST[l])
    ) u_level (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .valid_i(lv_valid[l]),
      .g_i    (lv_g[l]),
      .p_i    (lv_p[l]),
      .sp_i   (lv_sp[l]),
      .valid_o(lv_valid[l+1]),
      .g_o    (lv_g[l+1]),
      .p_o    (lv_p[l+1]),
      .sp_o   (lv_sp[l+1])
    );
  end

  // Final carries. Five levels span 32 entries, so every group already
  // reaches the carry-in slot except the top one (bit 31 -> bit 0). Folding
  // the carry-in into every group fixes that entry; for the others the group
  // propagate is already 0 (p at the carry-in slot is 0), so they are unchanged.
  always_comb begin
    carry_full = {NGP{1'b0}};
    gp_tmp     = '{g: 1'b0, p: 1'b0};
    for (int k = 0; k < NGP; k++) begin
      gp_tmp = combine(gp_t'{g: lv_g[LEVELS][k], p: lv_p[LEVELS][k]},
                       gp_t'{g: lv_g[LEVELS][0], p: 1'b0});
      carry_full[k] = gp_tmp.g;
    end
  end

  // Result and flags straight from the S5 registers. carry_full[i] is the
  // carry into bit i; carry_full[0] is the captured sub bit.
  always_comb begin
    result = lv_sp[LEVELS] ^ carry_full[WIDTH-1:0];
    cout   = carry_full[WIDTH];
    ovf    = carry_full[WIDTH-1] ^ carry_full[WIDTH];
    borrow = lv_g[LEVELS][0] & ~carry_full[WIDTH];
    zero   = (result == {WIDTH{1'b0}}) & out_valid;
  end

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
`timescale 1ns/1ps
module tb_prefix_addsub_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    exp_t        e;
  } vec_t;

  logic        clk, rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic        cout, borrow, ovf, zero;
  logic [31:0] op_a, op_b, result;

  int   total;
  int   bad;
  exp_t q[$];
  vec_t tbl [7];
  bit   pat [6];

  prefix_addsub_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .borrow   (borrow),
    .ovf      (ovf),
    .zero     (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [63:0] wide;
    longint      sa, sb, ideal;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      e.res  = a - b;
      e.cout = (a >= b);
      ideal  = sa - sb;
    end else begin
      e.res  = a + b;
      wide   = {32'd0, a} + {32'd0, b};
      e.cout = (wide >= 64'h1_0000_0000);
      ideal  = sa + sb;
    end
    e.borrow = s & ~e.cout;
    e.ovf    = (ideal != longint'($signed(e.res)));
    e.zero   = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock with scoreboard checks; entered and left at posedge+1.
  task automatic cycle(output bit acc);
    bit   out_fire, hold;
    exp_t got, snap, now;
    #2;
    got      = {result, cout, borrow, ovf, zero};
    acc      = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got out_valid=1 result=%h required no beat", result);
      end else begin
        chk("stream_data", 64'(got), 64'(q[0]));
        if (out_fire) void'(q.pop_front());
      end
    end
    if (acc) q.push_back(model(op_a, op_b, sub));
    hold = out_valid && !out_ready;
    snap = got;
    @(posedge clk);
    #1;
    if (hold) begin
      now = {result, cout, borrow, ovf, zero};
      chk("stall_stable", 64'({out_valid, now}), 64'({1'b1, snap}));
    end
  endtask

  task automatic run_stream(input int n, input bit rnd);
    int sent, guard;
    bit acc;
    sent     = 0;
    guard    = 0;
    in_valid = 1'b0;
    while ((sent < n || q.size() != 0) && guard < 4000) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : pat[guard % 6];
      if (sent < n && !in_valid) begin
        if (rnd) begin
          in_valid = ($urandom_range(0, 4) != 0);
          op_a     = rand_op();
          op_b     = rand_op();
          sub      = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b1;
          op_a     = 32'(sent);
          op_b     = 32'(3 * sent);
          sub      = 1'(sent % 2);
        end
      end
      cycle(acc);
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_sent", 64'(sent), 64'(n));
    chk("stream_drained", 64'(q.size()), 64'd0);
  endtask

  // Single beat into an idle pipe: latency, table values, then drain.
  task automatic apply_vec(input int t);
    int   n;
    exp_t got;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op_a      = tbl[t].a;
    op_b      = tbl[t].b;
    sub       = tbl[t].s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n        = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("vec%0d_latency", t), 64'(n), 64'd6);
    got = {result, cout, borrow, ovf, zero};
    chk($sformatf("vec%0d_result", t), 64'(got), 64'(tbl[t].e));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_drained", t), 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit acc;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    sub       = 1'b0;
    pat       = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    //            a              b              sub   res            cout  brw   ovf   zero
    tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1}};

    #3;
    chk("reset_state", 64'({out_valid, in_ready, result, cout, borrow, ovf, zero}),
        64'({1'b0, 1'b1, 32'd0, 4'b0000}));
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 7; t++) apply_vec(t);

    // Mid-stream reset with three beats in flight, the oldest at the output.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      op_a     = 32'(k + 10);
      op_b     = 32'(k + 1);
      sub      = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset", 64'({out_valid, in_ready, result, cout}), 64'({1'b0, 1'b1, 32'd0, 1'b0}));
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    for (int k = 0; k < 10; k++) cycle(acc);

    apply_vec(0);
    run_stream(8, 1'b0);
    run_stream(300, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
